// File: rtl/udm_bus_pkg.sv
// Shared udm bus definitions: field widths, master IDs and the request payload struct.
package udm_bus_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_BEW = 4;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  typedef struct packed {
    logic               we;
    logic [BUS_AW-1:0]  addr;
    logic [BUS_BEW-1:0] be;
    logic [BUS_DW-1:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/udm_id_fifo.sv
// In-order synchronous FIFO holding the issuing master ID of each outstanding read.
module udm_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_o  = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/udm_bus_arb2.sv
// Two-master round-robin arbiter for the udm req/ack/resp bus; read responses are
// routed back to their issuer through an in-order master-ID FIFO.
module udm_bus_arb2
  import udm_bus_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH = 4,
  parameter bit          M0_PRIO_RST = 1'b1
) (
  input  logic               clk_i,
  input  logic               rstn_i,

  input  logic               m0_req_i,
  input  logic               m0_we_i,
  input  logic [BUS_AW-1:0]  m0_addr_bi,
  input  logic [BUS_BEW-1:0] m0_be_bi,
  input  logic [BUS_DW-1:0]  m0_wdata_bi,
  output logic               m0_ack_o,
  output logic               m0_resp_o,
  output logic [BUS_DW-1:0]  m0_rdata_bo,

  input  logic               m1_req_i,
  input  logic               m1_we_i,
  input  logic [BUS_AW-1:0]  m1_addr_bi,
  input  logic [BUS_BEW-1:0] m1_be_bi,
  input  logic [BUS_DW-1:0]  m1_wdata_bi,
  output logic               m1_ack_o,
  output logic               m1_resp_o,
  output logic [BUS_DW-1:0]  m1_rdata_bo,

  output logic               s_req_o,
  output logic               s_we_o,
  output logic [BUS_AW-1:0]  s_addr_bo,
  output logic [BUS_BEW-1:0] s_be_bo,
  output logic [BUS_DW-1:0]  s_wdata_bo,
  input  logic               s_ack_i,
  input  logic               s_resp_i,
  input  logic [BUS_DW-1:0]  s_rdata_bi,

  output logic               err_o
);

  bus_req_t m0_pl;
  bus_req_t m1_pl;
  bus_req_t sel_pl;

  logic rr_ptr;
  logic grant;
  logic elig0;
  logic elig1;
  logic read_room;
  logic fire;
  logic id_push;
  logic resp_hit;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;

  assign m0_pl = '{we: m0_we_i, addr: m0_addr_bi, be: m0_be_bi, wdata: m0_wdata_bi};
  assign m1_pl = '{we: m1_we_i, addr: m1_addr_bi, be: m1_be_bi, wdata: m1_wdata_bi};

  // A full FIFO still admits a read in a cycle where a response frees the head slot.
  assign read_room = ~fifo_full | s_resp_i;
  assign elig0     = m0_req_i & (m0_we_i | read_room);
  assign elig1     = m1_req_i & (m1_we_i | read_room);

  always_comb begin
    grant = MID_M0;
    if (elig0 & elig1) grant = rr_ptr;
    else if (elig1)    grant = MID_M1;
  end

  assign s_req_o    = elig0 | elig1;
  assign sel_pl     = s_req_o ? ((grant == MID_M1) ? m1_pl : m0_pl) : '0;
  assign s_we_o     = sel_pl.we;
  assign s_addr_bo  = sel_pl.addr;
  assign s_be_bo    = sel_pl.be;
  assign s_wdata_bo = sel_pl.wdata;

  assign fire     = s_req_o & s_ack_i;
  assign m0_ack_o = fire & (grant == MID_M0);
  assign m1_ack_o = fire & (grant == MID_M1);
  assign id_push  = fire & ~sel_pl.we;

  // Responses with no outstanding read are dropped here and flagged in err_o.
  assign resp_hit    = s_resp_i & ~fifo_empty;
  assign m0_resp_o   = resp_hit & (fifo_head == MID_M0);
  assign m1_resp_o   = resp_hit & (fifo_head == MID_M1);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  udm_id_fifo #(
    .WIDTH (1),
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (id_push),
    .data_i  (grant),
    .pop_i   (s_resp_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Pointer moves away from the winner only when a transfer actually fires.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rr_ptr <= M0_PRIO_RST ? MID_M0 : MID_M1;
      err_o  <= 1'b0;
    end else begin
      if (fire) rr_ptr <= ~grant;
      if (s_resp_i & fifo_empty) err_o <= 1'b1;
    end
  end

endmodule
